reset_sequencer: RTL and testbench

//  Ordered reset-release controller for N_DOM downstream reset domains. Fed by
//  the reset_cdc output: asserts all domain resets asynchronously with rst_in,

---
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds every downstream domain in reset while
// rst_in is high, then releases domains one at a time (0 first), gating each
// release on the previous domain's ready handshake. Ready timeouts trigger a
// bounded number of automatic re-sequences before parking in FAIL.
module reset_sequencer #(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned POR_CYCLES  = 16,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned RDY_TIMEOUT = 256,
  parameter int unsigned MAX_RETRY   = 2,
  localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1,
  localparam int unsigned RET_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             sw_rst_req,
  input  logic [N_DOM-1:0] rdy,
  output logic [N_DOM-1:0] rst_out,
  output logic             all_ready,
  output logic             fault,
  output logic [IDX_W-1:0] fault_dom,
  output logic [RET_W-1:0] retry_cnt
);

  localparam int unsigned MAX_PG = (POR_CYCLES > GAP_CYCLES) ? POR_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_PG > RDY_TIMEOUT) ? MAX_PG : RDY_TIMEOUT;
  localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_WAIT_RDY = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_FAIL     = 3'd4;

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);
  localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRY);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [N_DOM-1:0] r_rst_out;
  logic             r_fault;
  logic [IDX_W-1:0] r_fault_dom;
  logic [RET_W-1:0] r_retry;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [N_DOM-1:0] w_rst_nxt;
  logic             w_fault_nxt;
  logic [IDX_W-1:0] w_fault_dom_nxt;
  logic [RET_W-1:0] w_retry_nxt;

  // Next-state logic; released domains always form a low-order prefix of zeros,
  // so releasing the next domain is a left shift of rst_out.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_rst_nxt       = r_rst_out;
    w_fault_nxt     = r_fault;
    w_fault_dom_nxt = r_fault_dom;
    w_retry_nxt     = r_retry;
    if (sw_rst_req) begin
      w_state_nxt = ST_INIT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_fault_nxt = 1'b0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_rst_nxt = '1;
          if (r_cnt == POR_LAST) begin
            w_rst_nxt   = {N_DOM{1'b1}} << 1;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_RDY;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          if (rdy[r_idx]) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_idx == IDX_LAST) ? ST_RUN : ST_GAP;
          end else if (r_cnt == TO_LAST) begin
            w_rst_nxt       = '1;
            w_fault_nxt     = 1'b1;
            w_fault_dom_nxt = r_idx;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            if (r_retry < RET_MAX) begin
              w_retry_nxt = r_retry + 1'b1;
              w_state_nxt = ST_INIT;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_rst_nxt   = r_rst_out << 1;
            w_idx_nxt   = r_idx + 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_RDY;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          w_rst_nxt = '0;
        end
        ST_FAIL: begin
          w_rst_nxt = '1;
        end
        default: begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_nxt   = '1;
        end
      endcase
    end
  end

  // State registers; rst_in forces every domain into reset immediately.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out   <= '1;
      r_fault     <= 1'b0;
      r_fault_dom <= '0;
      r_retry     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rst_out   <= w_rst_nxt;
      r_fault     <= w_fault_nxt;
      r_fault_dom <= w_fault_dom_nxt;
      r_retry     <= w_retry_nxt;
    end
  end

  assign rst_out   = r_rst_out;
  assign all_ready = (r_state == ST_RUN);
  assign fault     = r_fault;
  assign fault_dom = r_fault_dom;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected output snapshots are queued with the edge
// number at which they must hold and compared when that edge has passed.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rdy = 3'b000;
  logic [2:0] rst_out;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_dom;
  logic [0:0] retry_cnt;

  reset_sequencer #(
    .N_DOM      (3),
    .POR_CYCLES (4),
    .GAP_CYCLES (2),
    .RDY_TIMEOUT(8),
    .MAX_RETRY  (1)
  ) u_dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .sw_rst_req(sw_rst_req),
    .rdy       (rdy),
    .rst_out   (rst_out),
    .all_ready (all_ready),
    .fault     (fault),
    .fault_dom (fault_dom),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [2:0] rst;
    logic       ar;
    logic       flt;
    logic [1:0] fd;
    logic       rt;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    edge_n = 0;
  string scen = "";

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", scen, tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int at, input logic [2:0] r, input logic ar, input logic flt,
                         input logic [1:0] fd, input logic rt);
    exp_t e;
    e.at = at; e.rst = r; e.ar = ar; e.flt = flt; e.fd = fd; e.rt = rt;
    sb_q.push_back(e);
  endtask

  // Advance one edge, check release ordering, then retire due expectations.
  task automatic step();
    exp_t  e;
    logic  ok;
    @(posedge clk);
    #1;
    edge_n++;
    ok = 1'b1;
    for (int j = 1; j < 3; j++) if (rst_out[j] == 1'b0 && rst_out[j-1] == 1'b1) ok = 1'b0;
    check_eq($sformatf("e%0d_order", edge_n), ok, 1);
    while (sb_q.size() > 0 && sb_q[0].at <= edge_n) begin
      e = sb_q.pop_front();
      check_eq($sformatf("e%0d_rst_out", e.at), rst_out, e.rst);
      check_eq($sformatf("e%0d_all_ready", e.at), all_ready, e.ar);
      check_eq($sformatf("e%0d_fault", e.at), fault, e.flt);
      check_eq($sformatf("e%0d_fault_dom", e.at), fault_dom, e.fd);
      check_eq($sformatf("e%0d_retry_cnt", e.at), retry_cnt, e.rt);
    end
  endtask

  task automatic run_to(input int e);
    for (int i = 0; i < 200 && edge_n < e; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) step();
    check_eq("sb_drain", sb_q.size(), 0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_rst_out", rst_out, 3'b111);
    check_eq("rst_all_ready", all_ready, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_fault_dom", fault_dom, 0);
    check_eq("rst_retry_cnt", retry_cnt, 0);
  endtask

  // Assert rst_in mid-cycle, check reset values, release before the next edge.
  task automatic apply_reset(input logic [2:0] r);
    @(negedge clk);
    rst_in = 1'b1;
    rdy = r;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_in = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // Nominal sequence with every ready already high.
    scen = "nominal";
    apply_reset(3'b111);
    sb_push(3, 3'b111, 0, 0, 0, 0);
    sb_push(4, 3'b110, 0, 0, 0, 0);
    sb_push(6, 3'b110, 0, 0, 0, 0);
    sb_push(7, 3'b100, 0, 0, 0, 0);
    sb_push(9, 3'b100, 0, 0, 0, 0);
    sb_push(10, 3'b000, 0, 0, 0, 0);
    sb_push(11, 3'b000, 1, 0, 0, 0);
    drain();
    // RUN ignores ready deassertion.
    rdy = 3'b000;
    sb_push(13, 3'b000, 1, 0, 0, 0);
    drain();

    // Asynchronous reset in RUN, then full restart.
    scen = "async_rst";
    rst_in = 1'b1;
    #1;
    check_reset_state();
    rdy = 3'b111;
    #2;
    rst_in = 1'b0;
    edge_n = 0;
    sb_push(3, 3'b111, 0, 0, 0, 0);
    sb_push(4, 3'b110, 0, 0, 0, 0);
    sb_push(7, 3'b100, 0, 0, 0, 0);
    sb_push(10, 3'b000, 0, 0, 0, 0);
    sb_push(11, 3'b000, 1, 0, 0, 0);
    drain();

    // Domain 1 never ready: one retry, then FAIL.
    scen = "timeout";
    apply_reset(3'b101);
    sb_push(7, 3'b100, 0, 0, 0, 0);
    sb_push(14, 3'b100, 0, 0, 0, 0);
    sb_push(15, 3'b111, 0, 1, 1, 1);
    sb_push(18, 3'b111, 0, 1, 1, 1);
    sb_push(19, 3'b110, 0, 1, 1, 1);
    sb_push(22, 3'b100, 0, 1, 1, 1);
    sb_push(29, 3'b100, 0, 1, 1, 1);
    sb_push(30, 3'b111, 0, 1, 1, 1);
    sb_push(40, 3'b111, 0, 1, 1, 1);
    drain();

    // Software re-sequence out of FAIL; fault_dom keeps its last value.
    scen = "sw_from_fail";
    edge_n = 0;
    rdy = 3'b111;
    sb_push(1, 3'b111, 0, 0, 1, 0);
    sb_push(4, 3'b111, 0, 0, 1, 0);
    sb_push(5, 3'b110, 0, 0, 1, 0);
    sb_push(11, 3'b000, 0, 0, 1, 0);
    sb_push(12, 3'b000, 1, 0, 1, 0);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    drain();

    // Software request wins over a timeout on the same edge.
    scen = "sw_vs_timeout";
    apply_reset(3'b000);
    sb_push(11, 3'b110, 0, 0, 0, 0);
    sb_push(12, 3'b111, 0, 0, 0, 0);
    sb_push(15, 3'b111, 0, 0, 0, 0);
    sb_push(16, 3'b110, 0, 0, 0, 0);
    run_to(11);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    drain();

    // Early/foreign ready activity is ignored; progress follows real samples.
    scen = "ignore_rdy";
    apply_reset(3'b100);
    sb_push(4, 3'b110, 0, 0, 0, 0);
    sb_push(6, 3'b110, 0, 0, 0, 0);
    sb_push(8, 3'b110, 0, 0, 0, 0);
    sb_push(9, 3'b100, 0, 0, 0, 0);
    sb_push(11, 3'b100, 0, 0, 0, 0);
    sb_push(14, 3'b000, 0, 0, 0, 0);
    sb_push(15, 3'b000, 1, 0, 0, 0);
    run_to(1);
    rdy = 3'b101;
    run_to(2);
    rdy = 3'b100;
    run_to(6);
    rdy = 3'b101;
    run_to(11);
    rdy = 3'b111;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
